// File: rtl/program_sequencer.sv
// Program sequencer: holds the program counter and selects the next program-memory
// address (increment, in-page jump, conditional jump, call/return, stall). Calls push
// their return address onto a small hardware stack, and returns pop from it.
module program_sequencer #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              jmp,
   input  logic              jmp_nz,
   input  logic [3:0]        jmp_addr,
   input  logic              dont_jmp,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] from_PS,
   output logic [3:0]        depth,
   output logic              stack_ovf,
   output logic              stack_unf
);

   localparam int unsigned PtrW     = $clog2(STACK_DEPTH);
   localparam logic [3:0]  DepthMax = 4'(STACK_DEPTH);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] page_tgt;
   logic [ADDR_W-1:0] stack_top;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
   logic [3:0]        depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push;
   logic              stack_empty;
   logic              stack_full;
   logic [PtrW-1:0]   push_idx;
   logic [PtrW-1:0]   top_idx;

   // Wraps modulo 2^ADDR_W, so 0xFF increments to 0x00.
   assign pc_inc   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   // Jumps and calls replace only the low nibble: control flow stays in the 16-word page.
   assign page_tgt = {pc_q[ADDR_W-1:4], jmp_addr};

   assign stack_empty = (depth_q == 4'd0);
   assign stack_full  = (depth_q == DepthMax);

   // The low bits of depth index the next free slot; the top entry sits one below.
   // When the stack is full the low bits wrap to 0 and top_idx lands on the last slot.
   assign push_idx  = depth_q[PtrW-1:0];
   assign top_idx   = push_idx - {{(PtrW-1){1'b0}}, 1'b1};
   assign stack_top = stack_q[top_idx];

   // Next-address selection and stack bookkeeping; ret outranks call, hold outranks all.
   always_comb begin
      pm_addr = pc_inc;
      push    = 1'b0;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (reset) begin
         pm_addr = '0;
      end else if (hold) begin
         pm_addr = pc_q;
      end else if (ret) begin
         if (stack_empty) begin
            unf_d = 1'b1;
         end else begin
            pm_addr = stack_top;
            depth_d = depth_q - 4'd1;
         end
      end else if (call) begin
         pm_addr = page_tgt;
         if (stack_full) begin
            ovf_d = 1'b1;
         end else begin
            push    = 1'b1;
            depth_d = depth_q + 4'd1;
         end
      end else if (jmp || (jmp_nz && !dont_jmp)) begin
         pm_addr = page_tgt;
      end
   end

   // PC, depth and sticky fault flags; async reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         depth_q <= 4'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pm_addr;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Return-address storage; only a push writes, a pop just moves the depth down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            stack_q[i] <= '0;
         end
      end else if (push) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign pc        = pc_q;
   assign from_PS   = pc_q;
   assign depth     = depth_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program sequencer for the 8-bit microcontroller core. Holds the program counter and computes the next program-memory address each cycle: increment, in-page jump, jump-if-not-zero, subroutine call and return (small hardware return stack), or stall. It sits directly upstream of the instruction decoder. `pm_addr` addresses the synchronous program ROM, whose output is the decoder's `next_instr`. The decoder's `jmp`, `jmp_nz` and `ir_nibble` outputs, plus planned `call` and `ret` decodes, feed back into this block.

## Interface
- `ADDR_W`, 8: program address width.
- `STACK_DEPTH`, 4: return-stack entries (power of two, 2..8).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `hold`  in  1  stall; PC and stack frozen.
- `jmp`  in  1  unconditional jump (decoder).
- `jmp_nz`  in  1  conditional jump (decoder).
- `jmp_addr`  in  4  jump/call target low nibble (decoder `ir_nibble`).
- `dont_jmp`  in  1  zero flag from the computational unit; 1 suppresses `jmp_nz`.
- `call`  in  1  subroutine call, same target form as `jmp`.
- `ret`  in  1  subroutine return.
- `pm_addr`  out  ADDR_W  combinational next address to program ROM.
- `pc`  out  ADDR_W  registered program counter.
- `from_PS`  out  ADDR_W  debug copy of `pc`.
- `depth`  out  4  current number of stack entries, range 0..STACK_DEPTH.
- `stack_ovf`  out  1  sticky; a call occurred with the stack full.
- `stack_unf`  out  1  sticky; a ret occurred with the stack empty.

## Operation
- Page target is `{pc[ADDR_W-1:4], jmp_addr}`. Jumps never leave the current 16-word page.
- `pm_addr` uses the following priority (first match wins):
  1. `reset`=1 -> 0.
  2. `hold`=1 -> `pc`.
  3. `ret` -> top of stack, and pop. If the stack is empty: `pc+1`, no pop, `stack_unf` set.
  4. `call` -> page target; push `pc+1`. If the stack is full: jump still taken, push discarded, `depth` unchanged, `stack_ovf` set.
  5. `jmp` -> page target.
  6. `jmp_nz` with `dont_jmp`=0 -> page target.
  7. Otherwise -> `pc+1`.
- `pc+1` is modulo 2^ADDR_W: 0xFF -> 0x00. A pushed return address wraps the same way.
- On each clock edge, `pc` <= `pm_addr`.
- Stack is LIFO; `depth` tracks the entry count.
- Simultaneous `call` and `ret`: `ret` wins, and `call` is ignored entirely (no push, no flag).
- `hold` overrides all other controls. No push, pop or flag update occurs while it is asserted.
- `stack_ovf` and `stack_unf` clear only on `reset`.
- `from_PS` = `pc` at all times.

## Timing
- Values during and after `reset`: `pc`=0, `depth`=0, `stack_ovf`=0, `stack_unf`=0, stack contents=0, `pm_addr`=0.
- Reset asserts asynchronously. On release, the first edge loads `pc` <= 1, since the ROM has already fetched address 0.
- `reset` asserted mid-call: stack and flags clear immediately. No partial push survives.
- `pm_addr` is combinational from `pc`, the stack top and the control inputs. The zero-latency path to the ROM address is required.
- Control inputs are sampled in the same cycle they are valid. The decoder's registered `ir` makes them valid one cycle after fetch.
- Branch effect: the target appears on `pm_addr` in the cycle `jmp` is high. `pc` holds the target after the next edge.
- Push/pop and the `depth` change take effect on the same edge as the `pc` update. A `ret` in the cycle after a `call` returns that call's pushed address.

## Test plan
- Increment and wrap: reset, release, run 300 cycles with no controls -> `pc` counts 1,2,…,0xFF,0x00,0x01; `pm_addr` = `pc+1` each cycle.
- Jumps: with `pc`=0x37 drive `jmp`, `jmp_addr`=0xA -> `pm_addr`=0x3A, `pc`=0x3A next edge. `jmp_nz` with `dont_jmp`=1 at `pc`=0x3A -> `pc`=0x3B. With `dont_jmp`=0 and `jmp_addr`=0x2 -> `pc`=0x32.
- Call/return nesting: calls at `pc`=0x10, 0x25, 0x40, 0x55 (`jmp_addr`=0) -> `depth`=4. Four rets -> `pc`=0x56, 0x41, 0x26, 0x11, then `depth`=0, both flags 0.
- Stack faults: fifth call at `pc`=0x60 with `jmp_addr`=0x3 -> `pc`=0x63, `depth`=4, `stack_ovf`=1. Drain four rets, then a fifth ret at `pc`=0x80 -> `pc`=0x81, `stack_unf`=1, and both flags persist.
- Hold and priority: at `pc`=0x20 assert `hold`+`jmp` for 3 cycles -> `pc` stays 0x20, `depth` unchanged. Then `call`+`ret` together with `depth`=1 and top=0x11 -> `pc`=0x11, `depth`=0.
- Async reset mid-run: with `depth`=2 and `stack_ovf`=1, assert `reset` between edges -> `pc`, `pm_addr`, `depth` and both flags are 0 immediately. After release, `pc`=1 on the first edge.
